// File: rtl/skolem_sweep_ctrl.sv
// skolem_sweep_ctrl
// Sweeps all 16 values of a 4-bit operand t through an external combinational
// Skolem datapath and checks the returned candidate x against the bvsge/bvneg
// invertibility condition: signed(-x) >= signed(t).
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        begin a sweep (accepted only while idle)
//   t_out[3:0]   operand currently presented to the datapath
//   x_in[3:0]    datapath candidate for t_out (settles within one cycle)
//   busy         high while sweeping (DRIVE/CHECK)
//   done         one-cycle pulse when a sweep completes
//   pass_cnt     vectors that satisfied the check
//   fail_cnt     vectors that violated the check
//   fail_seen    sticky: at least one vector failed
//   first_fail_t t of the first failing vector, 0 if none
//
// Build option: define SKOLEM_SWEEP_STOP_ON_FAIL_EN to end the sweep at the
// first failing vector (t_out is left at the failing t).
module skolem_sweep_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] t_out,
    input  logic [3:0] x_in,
    output logic       busy,
    output logic       done,
    output logic [4:0] pass_cnt,
    output logic [4:0] fail_cnt,
    output logic       fail_seen,
    output logic [3:0] first_fail_t
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] t;
    logic [3:0] neg_x;
    logic       pass;

    // Two's-complement negation truncated to 4 bits, then signed compare.
    assign neg_x = ~x_in + 4'd1;
    assign pass  = $signed(neg_x) >= $signed(t);

    assign t_out = t;
    assign busy  = (state == DRIVE) || (state == CHECK);
    assign done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = DRIVE;
            DRIVE: state_next = CHECK;
            CHECK: begin
`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
                if (!pass || t == 4'hF) begin
                    state_next = DONE;
                end else begin
                    state_next = DRIVE;
                end
`else
                if (t == 4'hF) begin
                    state_next = DONE;
                end else begin
                    state_next = DRIVE;
                end
`endif
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t            <= '0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            fail_seen    <= 1'b0;
            first_fail_t <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        t            <= '0;
                        pass_cnt     <= '0;
                        fail_cnt     <= '0;
                        fail_seen    <= 1'b0;
                        first_fail_t <= '0;
                    end
                end
                CHECK: begin
                    if (pass) begin
                        pass_cnt <= pass_cnt + 5'd1;
                    end else begin
                        fail_cnt  <= fail_cnt + 5'd1;
                        fail_seen <= 1'b1;
                        if (!fail_seen) begin
                            first_fail_t <= t;
                        end
                    end
                    // t only advances when another vector follows, so a
                    // stop-on-fail exit leaves the failing t on t_out.
                    if (state_next == DRIVE) begin
                        t <= t + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
module tb_skolem_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] t_out;
    logic [3:0] x_in;
    logic       busy;
    logic       done;
    logic [4:0] pass_cnt;
    logic [4:0] fail_cnt;
    logic       fail_seen;
    logic [3:0] first_fail_t;

    // Behaviour of the external Skolem datapath: a lookup indexed by t.
    logic [3:0] xmap [16];
    assign x_in = xmap[t_out];

    int total = 0;
    int bad   = 0;

    // Expected results for the current sweep.
    int e_pass, e_fail, e_seen, e_first, e_lat, e_tfin;

    typedef struct {
        int mode;    // 0: x constant, 1: x = -t (correct Skolem function)
        int xval;
        int pass_e, fail_e, seen_e, first_e, lat_e, tfin_e;
    } vec_t;

    vec_t tbl [6];

    skolem_sweep_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .t_out        (t_out),
        .x_in         (x_in),
        .busy         (busy),
        .done         (done),
        .pass_cnt     (pass_cnt),
        .fail_cnt     (fail_cnt),
        .fail_seen    (fail_seen),
        .first_fail_t (first_fail_t)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".t_out"},        int'(t_out), 0);
        check({tag, ".busy"},         int'(busy), 0);
        check({tag, ".done"},         int'(done), 0);
        check({tag, ".pass_cnt"},     int'(pass_cnt), 0);
        check({tag, ".fail_cnt"},     int'(fail_cnt), 0);
        check({tag, ".fail_seen"},    int'(fail_seen), 0);
        check({tag, ".first_fail_t"}, int'(first_fail_t), 0);
    endtask

    // Reference: walk t = 0..15 with plain integer arithmetic.
    task automatic model();
        int negx, sn, st;
        e_pass = 0; e_fail = 0; e_seen = 0; e_first = 0; e_lat = 0; e_tfin = 15;
        for (int t = 0; t < 16; t++) begin
            negx  = (16 - int'(xmap[t])) % 16;
            sn    = (negx >= 8) ? negx - 16 : negx;
            st    = (t >= 8) ? t - 16 : t;
            e_lat = 2 * t + 2;
            if (sn >= st) begin
                e_pass++;
            end else begin
                if (e_seen == 0) e_first = t;
                e_seen = 1;
                e_fail++;
`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
                e_tfin = t;
                break;
`endif
            end
        end
    endtask

    task automatic set_neg_t();
        for (int t = 0; t < 16; t++) xmap[t] = 4'(16 - t);
    endtask

    task automatic set_const(input int v);
        for (int t = 0; t < 16; t++) xmap[t] = 4'(v);
    endtask

    // Start a sweep on edge N, wait for done, check results and hold.
    task automatic run_sweep(input string tag);
        int cnt;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, ".busy"}, int'(busy), 1);
        cnt = 0;
        while (cnt < 64) begin
            @(posedge clk);
            #1;
            cnt++;
            if (done) break;
        end
        check({tag, ".latency"},     cnt, e_lat);
        check({tag, ".pass_cnt"},    int'(pass_cnt), e_pass);
        check({tag, ".fail_cnt"},    int'(fail_cnt), e_fail);
        check({tag, ".fail_seen"},   int'(fail_seen), e_seen);
        check({tag, ".first_fail"},  int'(first_fail_t), e_first);
        check({tag, ".t_out"},       int'(t_out), e_tfin);
        @(posedge clk);
        #1;
        check({tag, ".done_pulse"},  int'(done), 0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, ".hold_pass"},   int'(pass_cnt), e_pass);
        check({tag, ".hold_fail"},   int'(fail_cnt), e_fail);
        check({tag, ".hold_first"},  int'(first_fail_t), e_first);
        check({tag, ".hold_t_out"},  int'(t_out), e_tfin);
        check({tag, ".hold_busy"},   int'(busy), 0);
    endtask

    initial begin
        int done_seen;

        // mode, xval, pass, fail, seen, first, latency, final t
        tbl[0] = '{1, 0, 16, 0, 0, 0, 32, 15};
        tbl[4] = '{0, 9, 16, 0, 0, 0, 32, 15};
`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
        tbl[1] = '{0, 0,  1, 1, 1, 1, 4, 1};
        tbl[2] = '{0, 8,  0, 1, 1, 0, 2, 0};
        tbl[3] = '{0, 1,  0, 1, 1, 0, 2, 0};
        tbl[5] = '{0, 15, 2, 1, 1, 2, 6, 2};
`else
        tbl[1] = '{0, 0,  9,  7, 1, 1, 32, 15};
        tbl[2] = '{0, 8,  1, 15, 1, 0, 32, 15};
        tbl[3] = '{0, 1,  8,  8, 1, 0, 32, 15};
        tbl[5] = '{0, 15, 10, 6, 1, 2, 32, 15};
`endif

        rst   = 1'b1;
        start = 1'b1;
        set_neg_t();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;

        // Directed table vectors.
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].mode == 1) set_neg_t();
            else set_const(tbl[i].xval);
            e_pass  = tbl[i].pass_e;
            e_fail  = tbl[i].fail_e;
            e_seen  = tbl[i].seen_e;
            e_first = tbl[i].first_e;
            e_lat   = tbl[i].lat_e;
            e_tfin  = tbl[i].tfin_e;
            run_sweep($sformatf("tbl%0d", i));
        end

        // Start re-pulsed on edges N+5 and N+32 must be ignored.
        set_neg_t();
        done_seen = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            start = (e == 5 || e == 32);
            @(posedge clk);
            #1;
            start = 1'b0;
            done_seen += int'(done);
            if (e == 6)  check("restart.no_clear", int'(pass_cnt), 3);
            if (e == 32) check("restart.done_at_32", int'(done), 1);
        end
        check("restart.single_done", done_seen, 1);
        check("restart.not_busy", int'(busy), 0);
        check("restart.pass_cnt", int'(pass_cnt), 16);

        // Reset on edge N+10 aborts the sweep without a done pulse.
        set_neg_t();
        done_seen = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            rst = (e == 10);
            @(posedge clk);
            #1;
            done_seen += int'(done);
            if (e == 9) check("abort.mid_pass", int'(pass_cnt), 4);
        end
        rst = 1'b0;
        check_reset_values("abort");
        repeat (40) begin
            @(posedge clk);
            #1;
            done_seen += int'(done);
        end
        check("abort.no_done", done_seen, 0);
        model();
        run_sweep("after_abort");

        // Randomized datapath behaviour against the reference model.
        for (int r = 0; r < 12; r++) begin
            for (int t = 0; t < 16; t++) begin
                // Bias towards correct answers so both passes and fails occur.
                if ($urandom_range(3) != 0) xmap[t] = 4'(16 - t + $urandom_range(2));
                else xmap[t] = 4'($urandom_range(15));
            end
            model();
            run_sweep($sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/skolem_sweep_ctrl.md
SKOLEM_SWEEP_CTRL -- requirements
Module: skolem_sweep_ctrl

Interface
REQ-001 SHALL provide clk  input  1  single clock; every register updates on its rising edge.
REQ-002 SHALL provide rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL provide start  input  1  request a full sweep; honoured only in IDLE.
REQ-004 SHALL provide t_out  output  4  operand t driven to the external combinational 4-bit Skolem datapath (bvsge/bvneg invertibility).
REQ-005 SHALL provide x_in  input  4  candidate x returned by that datapath for t_out; combinationally settled within one cycle.
REQ-006 SHALL provide busy  output  1  high in DRIVE and CHECK.
REQ-007 SHALL provide done  output  1  one-cycle pulse on sweep completion.
REQ-008 SHALL provide pass_cnt  output  5  number of vectors that satisfied the check (0..16).
REQ-009 SHALL provide fail_cnt  output  5  number of vectors that violated the check (0..16).
REQ-010 SHALL provide fail_seen  output  1  sticky flag, set when any vector fails.
REQ-011 SHALL provide first_fail_t  output  4  t value of the first failing vector; 0 if none.

Function
REQ-012 SHALL implement FSM states IDLE, DRIVE, CHECK, DONE.
REQ-013 SHALL, in IDLE with start=1: clear pass_cnt, fail_cnt, fail_seen and first_fail_t, load t=0, and go to DRIVE.
REQ-014 SHALL, in DRIVE: hold t_out stable, then go unconditionally to CHECK after one cycle.
REQ-015 SHALL, in CHECK, evaluate pass = signed(-x_in mod 16) >= signed(t_out), where -x = (~x_in + 1) truncated to 4 bits and both operands are 4-bit two's complement.
REQ-016 SHALL, in CHECK: increment pass_cnt on pass; otherwise increment fail_cnt and set fail_seen; load first_fail_t only on the first failure.
REQ-017 SHALL, in CHECK with t_out != 15: increment t and go to DRIVE; with t_out == 15 go to DONE (no wrap to 0).
REQ-018 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-019 SHALL hold all result outputs stable from DONE until the next accepted start.
REQ-020 SHALL ignore start in DRIVE, CHECK and DONE; no restart and no counter clear.
REQ-021 SHALL take 2 cycles per vector, so that with start sampled on edge N, DONE is entered on edge N+32.
REQ-022 SHALL keep t_out equal to the internal t register in all states, and at 0 in IDLE after reset.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, force state IDLE, t_out=0, busy=0, done=0, pass_cnt=0, fail_cnt=0, fail_seen=0 and first_fail_t=0.
REQ-024 SHALL let rst take priority over start and over every FSM transition, including an abort mid-sweep; no done pulse is generated by an aborted sweep.

Configuration
REQ-025 SHALL support macro SKOLEM_SWEEP_STOP_ON_FAIL_EN.
REQ-026 SHALL, with SKOLEM_SWEEP_STOP_ON_FAIL_EN defined, go from CHECK directly to DONE on the first failing vector, leaving t_out at the failing t.
REQ-027 SHALL, without SKOLEM_SWEEP_STOP_ON_FAIL_EN, always sweep all 16 vectors regardless of failures.

Verification
REQ-028 SHALL cover correct Skolem model (x = any value with -x >=s t, e.g. t=7 -> x=9): start -> done on edge N+32, pass_cnt=16, fail_cnt=0, fail_seen=0, first_fail_t=0.
REQ-029 SHALL cover x_in stuck at 0 with the macro undefined: -> pass_cnt=9, fail_cnt=7 (t=1..7), fail_seen=1, first_fail_t=1.
REQ-030 SHALL cover x_in stuck at 0 with the macro defined: -> done on edge N+4, pass_cnt=1, fail_cnt=1, first_fail_t=1, t_out=1.
REQ-031 SHALL cover start pulsed again at edges N+5 and N+32: -> ignored; single done pulse; counters not cleared mid-sweep.
REQ-032 SHALL cover rst at edge N+10: -> all outputs at reset values the next cycle, no done pulse; a subsequent start completes a clean sweep with pass_cnt=16.
